// File: rtl/ias_cmd_tracer.sv
// Passive IAS command observer: detects each new command, waits a settle time,
// samples the IAS result and queues a trace record in a show-ahead FIFO.
module ias_cmd_tracer #(
   parameter int DEPTH  = 8,
   parameter int SETTLE = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               opcode,
   input  logic [7:0]               address,
   input  logic [7:0]               data_in,
   input  logic [7:0]               data_out,
   input  logic                     trace_en,
   input  logic                     rd_en,
   input  logic                     clr_overflow,
   output logic                     rec_valid,
   output logic [7:0]               rec_opcode,
   output logic [7:0]               rec_address,
   output logic [7:0]               rec_data_in,
   output logic [7:0]               rec_result,
   output logic [7:0]               rec_seq,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int NW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [NW-1:0] CNT_LOAD = NW'(SETTLE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

   state_t        state_reg, state_next;
   logic [23:0]   cmd_t;
   logic [23:0]   prev_t_reg;
   logic [23:0]   cur_reg, cur_next;
   logic [NW-1:0] cnt_reg, cnt_next;
   logic          start;
   logic          capture;
   logic [7:0]    seq_reg;
   logic [39:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          overflow_reg;
   logic          pop, push, drop, is_full;
   logic [39:0]   head;

   assign cmd_t = {opcode, address, data_in};
   // A held command matches prev_t_reg after its first edge, so it starts only once.
   assign start = (opcode != 8'd0) && (cmd_t != prev_t_reg) && trace_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= '0;
         cur_reg    <= '0;
         prev_t_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         cur_reg    <= cur_next;
         prev_t_reg <= cmd_t;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cur_next   = cur_reg;
      capture    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               cur_next   = cmd_t;
               cnt_next   = CNT_LOAD;
               state_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (start) begin
               cur_next = cmd_t;
               cnt_next = CNT_LOAD;
            end else if (opcode == 8'd0) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == '0) begin
               state_next = ST_CAPTURE;
            end else begin
               cnt_next = cnt_reg - NW'(1);
            end
         end
         ST_CAPTURE: begin
            capture = 1'b1;
            if (start) begin
               cur_next   = cmd_t;
               cnt_next   = CNT_LOAD;
               state_next = ST_SETTLE;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign is_full = (count_reg == DEPTH_C);
   assign pop     = rd_en && (count_reg != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push    = capture && (!is_full || pop);
   assign drop    = capture && is_full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= {cur_reg, data_out, seq_reg};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         seq_reg      <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (push && !pop)      count_reg <= count_reg + CW'(1);
         else if (!push && pop) count_reg <= count_reg - CW'(1);
         if (capture) seq_reg <= seq_reg + 8'd1;
         if (drop)              overflow_reg <= 1'b1;
         else if (clr_overflow) overflow_reg <= 1'b0;
      end
   end

   assign head        = (count_reg != '0) ? mem[rd_ptr_reg] : '0;
   assign rec_opcode  = head[39:32];
   assign rec_address = head[31:24];
   assign rec_data_in = head[23:16];
   assign rec_result  = head[15:8];
   assign rec_seq     = head[7:0];
   assign rec_valid   = (count_reg != '0);
   assign count       = count_reg;
   assign full        = is_full;
   assign overflow    = overflow_reg;
endmodule

// File: tb/tb_ias_cmd_tracer.sv
// Bench for ias_cmd_tracer: directed scenarios plus random traffic, every cycle
// compared against a deadline-based command model and a queue-based FIFO model.
module tb_ias_cmd_tracer;
   localparam int DEPTH  = 8;
   localparam int SETTLE = 3;

   logic       clk, reset;
   logic [7:0] opcode, address, data_in, data_out;
   logic       trace_en, rd_en, clr_overflow;
   logic       rec_valid, full, overflow;
   logic [7:0] rec_opcode, rec_address, rec_data_in, rec_result, rec_seq;
   logic [3:0] count;

   ias_cmd_tracer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .address(address),
      .data_in(data_in), .data_out(data_out), .trace_en(trace_en),
      .rd_en(rd_en), .clr_overflow(clr_overflow), .rec_valid(rec_valid),
      .rec_opcode(rec_opcode), .rec_address(rec_address),
      .rec_data_in(rec_data_in), .rec_result(rec_result), .rec_seq(rec_seq),
      .count(count), .full(full), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a pending command is due SETTLE+1 edges after detection.
   logic [23:0] m_prev, m_cur;
   bit          m_pend, m_ovf;
   int          m_due, cyc;
   logic [7:0]  m_seq;
   logic [39:0] m_q[$];

   task automatic model_reset();
      m_prev = '0; m_cur = '0; m_pend = 0; m_ovf = 0; m_due = 0; m_seq = '0;
      m_q.delete();
   endtask

   task automatic model_edge();
      logic [23:0] t;
      logic [39:0] rec, dummy;
      bit start, cap;
      t     = {opcode, address, data_in};
      start = (opcode != 0) && (t != m_prev) && trace_en;
      cap   = 0;
      rec   = '0;
      if (m_pend && cyc == m_due) begin
         cap = 1; rec = {m_cur, data_out, m_seq}; m_pend = 0;
      end else if (m_pend && opcode == 0) begin
         m_pend = 0;
      end
      if (start) begin
         m_pend = 1; m_cur = t; m_due = cyc + SETTLE + 1;
      end
      m_prev = t;
      if (rd_en && m_q.size() != 0) dummy = m_q.pop_front();
      if (cap) begin
         if (m_q.size() == DEPTH) m_ovf = 1;
         else begin
            m_q.push_back(rec);
            if (clr_overflow) m_ovf = 0;
         end
         m_seq = m_seq + 8'd1;
      end else if (clr_overflow) begin
         m_ovf = 0;
      end
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [39:0] hd;
      hd = (m_q.size() != 0) ? m_q[0] : 40'd0;
      chk("rec_valid", 64'(rec_valid), 64'(m_q.size() != 0));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("full", 64'(full), 64'(m_q.size() == DEPTH));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("record", {24'd0, rec_opcode, rec_address, rec_data_in, rec_result, rec_seq},
          {24'd0, hd});
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] dout, input int n);
      opcode = op; address = a; data_in = d; data_out = dout;
      repeat (n) tick();
   endtask

   task automatic idle(input int n);
      opcode = 0; address = 0; data_in = 0;
      repeat (n) tick();
   endtask

   task automatic drain();
      rd_en = 1;
      repeat (DEPTH + 1) tick();
      rd_en = 0;
   endtask

   task automatic do_reset();
      #2 reset = 1;
      #1 model_reset();
      check_all();
      #1 reset = 0;
   endtask

   initial begin
      reset = 1; opcode = 0; address = 0; data_in = 0; data_out = 0;
      trace_en = 1; rd_en = 0; clr_overflow = 0; cyc = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all();
      chk("reset_count", 64'(count), 64'd0);
      reset = 0;

      // Single held command yields one record, visible 4 edges after detection.
      cmd(8'd1, 8'd1, 8'd0, 8'd150, 4);
      chk("t1_not_yet", 64'(rec_valid), 64'd0);
      tick();
      chk("t1_valid", 64'(rec_valid), 64'd1);
      tick();
      chk("t1_count", 64'(count), 64'd1);
      chk("t1_result", 64'(rec_result), 64'd150);
      chk("t1_seq", 64'(rec_seq), 64'd0);
      idle(3);
      drain();

      // Back-to-back commands, result 75 during ADD.
      do_reset();
      cmd(8'd2, 8'd11, 8'd25, 8'd10, 4);
      cmd(8'd2, 8'd12, 8'd50, 8'd20, 4);
      cmd(8'd1, 8'd11, 8'd0, 8'd25, 4);
      cmd(8'd3, 8'd12, 8'd0, 8'd75, 4);
      idle(4);
      chk("t2_count", 64'(count), 64'd4);
      rd_en = 1;
      repeat (3) tick();
      chk("t2_add_result", 64'(rec_result), 64'd75);
      chk("t2_add_seq", 64'(rec_seq), 64'd3);
      tick();
      rd_en = 0;
      chk("t2_drained", 64'(rec_valid), 64'd0);

      // Mid-settle address change abandons the first command.
      do_reset();
      cmd(8'd1, 8'd1, 8'd0, 8'd5, 2);
      cmd(8'd1, 8'd2, 8'd0, 8'd6, 6);
      idle(2);
      chk("t3_count", 64'(count), 64'd1);
      chk("t3_addr", 64'(rec_address), 64'd2);
      chk("t3_seq", 64'(rec_seq), 64'd0);

      // Nine commands, no reads: ninth dropped.
      do_reset();
      for (int i = 0; i < 9; i++) cmd(8'd4, 8'(i), 8'(i * 3), 8'($urandom), 5);
      idle(2);
      chk("t4_full", 64'(full), 64'd1);
      chk("t4_ovf", 64'(overflow), 64'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk("t4_drain_seq", 64'(rec_seq), 64'(i));
         rd_en = 1; tick(); rd_en = 0;
      end
      clr_overflow = 1; tick(); clr_overflow = 0;
      chk("t4_ovf_clr", 64'(overflow), 64'd0);

      // Full FIFO with a pop on the capture edge.
      do_reset();
      for (int i = 0; i < DEPTH; i++) cmd(8'd5, 8'(i), 8'd0, 8'($urandom), 5);
      opcode = 8'd6; address = 8'd99;
      repeat (4) tick();
      rd_en = 1; tick(); rd_en = 0;
      chk("t5_count", 64'(count), 64'd8);
      chk("t5_ovf", 64'(overflow), 64'd0);
      chk("t5_head", 64'(rec_seq), 64'd1);
      idle(1);
      drain();

      // Reset mid-settle with three records stored.
      for (int i = 0; i < 3; i++) cmd(8'd7, 8'(i), 8'd1, 8'd9, 5);
      cmd(8'd8, 8'd40, 8'd2, 8'd33, 2);
      do_reset();
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_rec", {rec_opcode, rec_address, rec_data_in, rec_result, rec_seq}, 64'd0);
      cmd(8'd8, 8'd41, 8'd2, 8'd44, 5);
      chk("t6_seq", 64'(rec_seq), 64'd0);
      chk("t6_valid", 64'(rec_valid), 64'd1);
      drain();

      // trace_en low and NOP commands produce nothing.
      trace_en = 0;
      for (int i = 0; i < 4; i++) cmd(8'(i + 1), 8'(i), 8'd0, 8'd1, 5);
      trace_en = 1;
      for (int i = 0; i < 4; i++) cmd(8'd0, 8'(i + 20), 8'(i), 8'd1, 5);
      chk("t7_count", 64'(count), 64'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         int hold;
         opcode  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
         address = 8'($urandom_range(0, 3));
         data_in = 8'($urandom_range(0, 3));
         hold    = $urandom_range(1, 7);
         for (int k = 0; k < hold; k++) begin
            data_out     = 8'($urandom);
            rd_en        = ($urandom_range(0, 3) == 0);
            trace_en     = ($urandom_range(0, 9) != 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            tick();
         end
         if (i % 97 == 50) do_reset();
      end
      rd_en = 0; clr_overflow = 0; trace_en = 1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
